// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Groups the fetch stage's bus signals: the instruction-memory port, the
// stall/redirect controls from the rest of the pipeline, the IF/ID pipeline
// register outputs and the cycle/performance counters.
//
// Modports:
//   master : the fetch stage itself (drives imem_addr, IF/ID and counters)
//   slave  : the environment (memory + pipeline control driving inputs)
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]  imem_addr;
    logic [BUS_WIDTH-1:0] imem_rdata;
    logic                 stall_i;
    logic                 redirect_valid;
    logic [PC_WIDTH-1:0]  redirect_pc;
    logic [BUS_WIDTH-1:0] instrD;
    logic [PC_WIDTH-1:0]  pcD;
    logic [PC_WIDTH-1:0]  pcplus1D;
    logic                 validD;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] perf_fetched;
    logic [CNT_WIDTH-1:0] perf_bubbles;
    logic [CNT_WIDTH-1:0] perf_stalls;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall_i,
        input  redirect_valid,
        input  redirect_pc,
        output instrD,
        output pcD,
        output pcplus1D,
        output validD,
        output cycle_count,
        output perf_fetched,
        output perf_bubbles,
        output perf_stalls
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall_i,
        output redirect_valid,
        output redirect_pc,
        input  instrD,
        input  pcD,
        input  pcplus1D,
        input  validD,
        input  cycle_count,
        input  perf_fetched,
        input  perf_bubbles,
        input  perf_stalls
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses a combinational instruction
// memory and registers the IF/ID pipeline register. Supports a start-up
// bubble, stall (hold), branch/jump redirect with a one-bubble squash and a
// free-running cycle counter.
//
// Ports:
//   CLK    : clock, all state changes on the rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : fetch_stage_if.master (imem port, stall/redirect, IF/ID, counters)
//
// Optional feature: define FETCH_PERF_EN to build the fetched/bubble/stall
// performance counters; otherwise perf_* outputs are constant zero.
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned          BUS_WIDTH = 32,
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [BUS_WIDTH-1:0] BUBBLE    = '0,
    parameter int unsigned          CNT_WIDTH = 32
) (
    input logic           CLK,
    input logic           RST_N,
    fetch_stage_if.master bus
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [BUS_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]  pcD_q, pcD_d;
    logic [PC_WIDTH-1:0]  pcPlus1_q, pcPlus1_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cycle_q;

    // State register, PC, IF/ID register and the free-running cycle counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            instr_q   <= BUBBLE;
            pcD_q     <= '0;
            pcPlus1_q <= '0;
            valid_q   <= 1'b0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcD_q     <= pcD_d;
            pcPlus1_q <= pcPlus1_d;
            valid_q   <= valid_d;
            cycle_q   <= cycle_q + CNT_ONE;
        end
    end

    // Next-state logic. BOOT always writes a bubble because the memory word
    // for the reset PC is only consumed from RUN onwards. In RUN a redirect
    // squashes the in-flight fetch and beats a simultaneous stall; pcD and
    // pcplus1D keep describing the last real instruction across a bubble.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pcD_d     = pcD_q;
        pcPlus1_d = pcPlus1_q;
        valid_d   = valid_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                instr_d = BUBBLE;
                valid_d = 1'b0;
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    pc_d    = bus.redirect_pc;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                end else if (!bus.stall_i) begin
                    instr_d   = bus.imem_rdata;
                    pcD_d     = pc_q;
                    pcPlus1_d = pc_q + PC_ONE;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + PC_ONE;
                end
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instrD      = instr_q;
    assign bus.pcD         = pcD_q;
    assign bus.pcplus1D    = pcPlus1_q;
    assign bus.validD      = valid_q;
    assign bus.cycle_count = cycle_q;

`ifdef FETCH_PERF_EN
    logic [CNT_WIDTH-1:0] perfFetched_q;
    logic [CNT_WIDTH-1:0] perfBubbles_q;
    logic [CNT_WIDTH-1:0] perfStalls_q;
    logic                 runAdvance;
    logic                 bubbleWrite;
    logic                 runHold;

    // Event decode mirrors the priority of the next-state logic.
    assign runAdvance  = (state_q == RUN) && !bus.redirect_valid && !bus.stall_i;
    assign bubbleWrite = (state_q == BOOT) || bus.redirect_valid;
    assign runHold     = (state_q == RUN) && !bus.redirect_valid && bus.stall_i;

    // Performance counters, each wrapping at 2^CNT_WIDTH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perfFetched_q <= '0;
            perfBubbles_q <= '0;
            perfStalls_q  <= '0;
        end else begin
            if (runAdvance) begin
                perfFetched_q <= perfFetched_q + CNT_ONE;
            end
            if (bubbleWrite) begin
                perfBubbles_q <= perfBubbles_q + CNT_ONE;
            end
            if (runHold) begin
                perfStalls_q <= perfStalls_q + CNT_ONE;
            end
        end
    end

    assign bus.perf_fetched = perfFetched_q;
    assign bus.perf_bubbles = perfBubbles_q;
    assign bus.perf_stalls  = perfStalls_q;
`else
    assign bus.perf_fetched = '0;
    assign bus.perf_bubbles = '0;
    assign bus.perf_stalls  = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Parametrised instruction-fetch (IF) stage for the pipelined CPU.
- Owns the PC and drives a combinational instruction memory.
- Registers the IF/ID pipeline register (instruction, PC, PC+1, valid).
- Beyond plain fetch with a bubble after start-up, it supports stall (hold), branch/jump redirect with one-bubble squash, a free-running cycle counter, and optional performance counters.

Parameters:
- BUS_WIDTH, 32, instruction word width.
- PC_WIDTH, 32, PC width; word addressing, so the increment is 1.
- RESET_PC, 0, PC value loaded at reset.
- BUBBLE, 0, instruction word inserted as a bubble; width BUS_WIDTH.
- CNT_WIDTH, 32, width of the cycle counter and the performance counters.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- imem_addr  out  PC_WIDTH  instruction memory address; always equals PC.
- imem_rdata  in  BUS_WIDTH  instruction at imem_addr; combinational, same cycle.
- stall_i  in  1  hold the PC and the IF/ID register this cycle.
- redirect_valid  in  1  taken branch/jump; load redirect_pc and squash the fetch.
- redirect_pc  in  PC_WIDTH  redirect target.
- instrD  out  BUS_WIDTH  IF/ID instruction.
- pcD  out  PC_WIDTH  PC of instrD.
- pcplus1D  out  PC_WIDTH  pcD+1, modulo 2^PC_WIDTH.
- validD  out  1  instrD is a real instruction (0 = bubble).
- cycle_count  out  CNT_WIDTH  cycles since reset release.
- perf_fetched  out  CNT_WIDTH  valid instructions written to ID (optional feature).
- perf_bubbles  out  CNT_WIDTH  bubbles written to ID (optional feature).
- perf_stalls  out  CNT_WIDTH  cycles with a hold applied (optional feature).

Behaviour:
- Reset (RST_N=0, asynchronous, any time including mid-operation):
  - PC=RESET_PC, instrD=BUBBLE, pcD=0, pcplus1D=0, validD=0.
  - cycle_count=0, all perf counters=0, state=BOOT.
- States: BOOT, RUN.
- BOOT, the first posedge after reset release:
  - PC held; ID gets BUBBLE with validD=0; go to RUN. stall_i is ignored.
  - If redirect_valid=1: PC<=redirect_pc, ID gets BUBBLE, go to RUN.
- RUN, per posedge, highest priority first:
  - redirect_valid=1: PC<=redirect_pc; instrD<=BUBBLE, validD<=0; pcD/pcplus1D unchanged. Redirect overrides a simultaneous stall_i.
  - stall_i=1: PC, instrD, pcD, pcplus1D, validD all held.
  - otherwise: instrD<=imem_rdata, pcD<=PC, pcplus1D<=PC+1, validD<=1, PC<=PC+1.
- Latency: an instruction at address A reaches instrD on the posedge at which PC=A.
- Sustained throughput: 1 instruction/cycle without stalls or redirects.
- Redirect cost: exactly one bubble; the target instruction appears on the second posedge after the redirect.
- Wrap-around:
  - PC increments modulo 2^PC_WIDTH; 2^PC_WIDTH-1 wraps to 0.
  - pcplus1D wraps the same way.
  - cycle_count increments every posedge after reset and wraps modulo 2^CNT_WIDTH.
- imem_addr is purely combinational from PC; no output has combinational dependence on stall_i or redirect_valid.
- A stall in which validD=0 holds the bubble; it does not become valid.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined, each counter increments by 1 per posedge:
  - perf_fetched on each RUN normal advance.
  - perf_bubbles on each BUBBLE write (BOOT or redirect).
  - perf_stalls on each RUN hold cycle.
  - All three reset to 0 and wrap modulo 2^CNT_WIDTH.
- Not defined: perf_* tied to constant 0, no counter flops; all other behaviour identical.

Test Plan:
- Reset release with memory word k = 0x1000_0000+k, no stall or redirect -> instrD=0/validD=0 after posedge 1; then 0x10000000 (pcD=0), 0x10000001 (pcD=1), one per cycle; cycle_count=5 after 5 posedges.
- stall_i=1 for 3 cycles while pcD=2 -> instrD, pcD=2 and PC=3 hold for 3 cycles; pcD=3 on the first posedge after release. With FETCH_PERF_EN, perf_stalls=3.
- redirect_valid=1, redirect_pc=0x40 while PC=5 -> one bubble (validD=0); next instrD=mem[0x40], pcD=0x40, pcplus1D=0x41. With FETCH_PERF_EN, perf_bubbles increments by 1.
- redirect_valid and stall_i both 1 -> redirect wins: bubble inserted, PC=redirect_pc.
- RESET_PC=0xFFFFFFFE -> pcD sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0; pcplus1D for pcD=0xFFFFFFFF is 0.
- RST_N driven low mid-run, asynchronously between edges -> outputs immediately return to their reset values; on release the BOOT bubble repeats, then fetch restarts at RESET_PC.
